ddr3_cmd_decoder: RTL and testbench
===================================

# ddr3_cmd_decoder

Memory-side command decoder and protocol checker for the DDR3 command bus. It samples the controller's command pins every rising `ck` edge and decodes MRS/REF/PRE/ACT/WR/RD/ZQ/NOP/DES. It holds the three mode registers and tracks the per-bank open/closed state with tRCD/tRP/tRFC timers. It reports each decoded command and any protocol violation, and sits in the DUV between the command pins and the data-path/array model.

## Interface
- `BA_BITS`, 3, bank address width (8 banks)
- `ADDR_BITS`, 14, address bus width
- `ROW_BITS`, 14, row address width
- `TRCD`, 6, ACT-to-RD/WR minimum, in `ck` cycles (≥2)
- `TRP`, 6, PRE-to-ACT minimum, in cycles (≥2)
- `TRFC`, 44, REF-to-next-command minimum, in cycles (≥2)

Ports:
- `ck` in 1: clock, all logic on posedge
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low
- `cke`, `cs_n`, `ras_n`, `cas_n`, `we_n` in 1 each: command pins
- `ba` in BA_BITS: bank address
- `addr` in ADDR_BITS: address (`addr[10]` = AP/all-banks/ZQ-long)
- `cmd_valid` out 1: one-cycle pulse per decoded non-NOP/DES command
- `cmd_code` out 4: `ddr3_cmd_e` of the reported command
- `cmd_bank` out BA_BITS, `cmd_addr` out ADDR_BITS: registered `ba`/`addr` of the command
- `cmd_row` out ROW_BITS: open row of `cmd_bank` (valid on RD/WR)
- `mode_reg0`, `mode_reg1`, `mode_reg2` out ADDR_BITS each: last MRS value per register
- `bank_open` out 2**BA_BITS: bit per bank, 1 = ACTIVATING or ACTIVE
- `err_valid` out 1, `err_code` out 3: one-cycle violation pulse and `ddr3_err_e` cause

## Operation
- Sample only when `cke`=1. When `cke`=0, treat the cycle as NOP; timers still count.
- Decode {cs_n,ras_n,cas_n,we_n}:
  - 0000 MRS, 0001 REF, 0010 PRE, 0011 ACT, 0100 WR, 0101 RD, 0110 ZQ, 0111 NOP.
  - cs_n=1 is DES.
- MRS with `ba`=0/1/2 loads mode_reg0/1/2 from `addr`; `ba`≥3 is ignored (reported, no update).
- Per-bank FSM:
  - IDLE -ACT-> ACTIVATING (row latched, timer=TRCD-1)
  - ACTIVATING -timer==0-> ACTIVE
  - ACTIVE or ACTIVATING -PRE-> PRECHARGING (timer=TRP-1)
  - PRECHARGING -timer==0-> IDLE
- PRE with `addr[10]`=1 precharges all non-IDLE banks. PRE to an IDLE or PRECHARGING bank is legal and does nothing.
- REF starts the global tRFC timer (TRFC-1).
- Violations; at most one per cycle, checked in this listed priority:
  - 1 ERR_TRFC: any non-NOP/DES while tRFC timer running
  - 2 ERR_ACT_OPEN: ACT to non-IDLE bank
  - 3 ERR_NOT_ACTIVE: RD/WR to bank not ACTIVE
  - 4 ERR_REF_OPEN: REF with any bank non-IDLE
  - 5 ERR_MRS_OPEN: MRS/ZQ with any bank non-IDLE
- An errored command is still reported on `cmd_*` but changes no state (no FSM, mode-reg, or timer update).
- Reset (async, any time, including mid-timer):
  - all banks IDLE, timers 0, mode regs 0, `bank_open`=0
  - `cmd_valid`=0, `cmd_code`=NOP, `cmd_bank`/`cmd_addr`/`cmd_row`=0
  - `err_valid`=0, `err_code`=0

## Timing
- Command sampled at edge n → `cmd_*`, `err_*` and mode-reg updates are visible after edge n (latency 1). `bank_open` changes after edge n.
- ACT at edge n: RD/WR at edge n+TRCD legal; at n+TRCD-1 gives ERR_NOT_ACTIVE.
- PRE at edge n: ACT at n+TRP legal; at n+TRP-1 gives ERR_ACT_OPEN.
- REF at edge n: any command at n+TRFC legal; at n+TRFC-1 gives ERR_TRFC.
- Back-to-back commands every cycle are supported. The pulses are not sticky.

## Structure
- `ddr3_pkg`:
  - `ddr3_cmd_e` (4-bit, encoding above; DES=4'b1000)
  - `ddr3_err_e` (0 = none)
  - `bank_state_e`
  - default timing constants
- Sub-module `ddr3_bank_fsm`, one per bank via generate: state, latched row, tRCD/tRP timer, legality outputs.
- Top level holds decode, global tRFC timer, mode regs and error priority.

## Test plan
- MRS ba=1 addr=14'h0044 → next cycle `cmd_valid`=1, `cmd_code`=MRS, `mode_reg1`=14'h0044, `err_valid`=0.
- ACT ba=2 row=14'h1ABC, RD ba=2 exactly TRCD=6 cycles later → RD reported with `cmd_row`=14'h1ABC, no error; the same at 5 cycles → `err_code`=3.
- Banks 0 and 5 active, PRE addr[10]=1 → `bank_open`=0; ACT bank 0 at +5 cycles → err 2, at +6 → accepted.
- REF with bank 3 open → err 4, no tRFC. REF all-idle then ACT at +43 → err 1, at +44 → accepted.
- `cke`=0 with ACT pins → no `cmd_valid`. ACT then `rst_n` low mid-tRCD → all outputs at reset values immediately, then RD after reset → err 3.

Source files
------------

// File: rtl/ddr3_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_pkg
// Shared types and defaults for the DDR3 command decoder slice.
//   ddr3_cmd_e   : 4-bit command code, {ras_n,cas_n,we_n} when cs_n=0, DES=8
//   ddr3_err_e   : 3-bit protocol violation cause, 0 = none
//   bank_state_e : per-bank FSM state
//   decodeCmd    : maps the raw command pins to a ddr3_cmd_e
// ---------------------------------------------------------------------------
package ddr3_pkg;

  localparam int DEF_BA_BITS   = 3;
  localparam int DEF_ADDR_BITS = 14;
  localparam int DEF_ROW_BITS  = 14;
  localparam int DEF_TRCD      = 6;
  localparam int DEF_TRP       = 6;
  localparam int DEF_TRFC      = 44;

  typedef enum logic [3:0] {
    CMD_MRS = 4'h0,
    CMD_REF = 4'h1,
    CMD_PRE = 4'h2,
    CMD_ACT = 4'h3,
    CMD_WR  = 4'h4,
    CMD_RD  = 4'h5,
    CMD_ZQ  = 4'h6,
    CMD_NOP = 4'h7,
    CMD_DES = 4'h8
  } ddr3_cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_TRFC       = 3'd1,
    ERR_ACT_OPEN   = 3'd2,
    ERR_NOT_ACTIVE = 3'd3,
    ERR_REF_OPEN   = 3'd4,
    ERR_MRS_OPEN   = 3'd5
  } ddr3_err_e;

  typedef enum logic [1:0] {
    BANK_IDLE        = 2'd0,
    BANK_ACTIVATING  = 2'd1,
    BANK_ACTIVE      = 2'd2,
    BANK_PRECHARGING = 2'd3
  } bank_state_e;

  // A deasserted cke masks the pins entirely, so the cycle reads as NOP.
  function automatic ddr3_cmd_e decodeCmd(input logic cke, input logic csN,
                                          input logic rasN, input logic casN,
                                          input logic weN);
    ddr3_cmd_e c;
    if (!cke)
      c = CMD_NOP;
    else if (csN)
      c = CMD_DES;
    else
      c = ddr3_cmd_e'({1'b0, rasN, casN, weN});
    return c;
  endfunction

endpackage

// File: rtl/ddr3_cmd_decoder_if.sv
// ---------------------------------------------------------------------------
// ddr3_cmd_decoder_if
// Bundles the DDR3 command pins and the decoder's report outputs.
//   master : drives cke/cs_n/ras_n/cas_n/we_n/ba/addr, observes reports
//   slave  : the decoder; samples pins, drives cmd_*, mode_reg*, bank_open,
//            err_*
// ---------------------------------------------------------------------------
interface ddr3_cmd_decoder_if #(
  parameter int BA_BITS   = 3,
  parameter int ADDR_BITS = 14,
  parameter int ROW_BITS  = 14
);

  logic                    cke;
  logic                    cs_n;
  logic                    ras_n;
  logic                    cas_n;
  logic                    we_n;
  logic [BA_BITS-1:0]      ba;
  logic [ADDR_BITS-1:0]    addr;

  logic                    cmd_valid;
  logic [3:0]              cmd_code;
  logic [BA_BITS-1:0]      cmd_bank;
  logic [ADDR_BITS-1:0]    cmd_addr;
  logic [ROW_BITS-1:0]     cmd_row;
  logic [ADDR_BITS-1:0]    mode_reg0;
  logic [ADDR_BITS-1:0]    mode_reg1;
  logic [ADDR_BITS-1:0]    mode_reg2;
  logic [2**BA_BITS-1:0]   bank_open;
  logic                    err_valid;
  logic [2:0]              err_code;

  modport master (
    output cke, cs_n, ras_n, cas_n, we_n, ba, addr,
    input  cmd_valid, cmd_code, cmd_bank, cmd_addr, cmd_row,
           mode_reg0, mode_reg1, mode_reg2, bank_open, err_valid, err_code
  );

  modport slave (
    input  cke, cs_n, ras_n, cas_n, we_n, ba, addr,
    output cmd_valid, cmd_code, cmd_bank, cmd_addr, cmd_row,
           mode_reg0, mode_reg1, mode_reg2, bank_open, err_valid, err_code
  );

endinterface

// File: rtl/ddr3_bank_fsm.sv
// ---------------------------------------------------------------------------
// ddr3_bank_fsm
// One DDR3 bank: IDLE/ACTIVATING/ACTIVE/PRECHARGING state, latched row and a
// shared tRCD/tRP countdown.
//   ck, rst_n  : clock, async active-low reset
//   i_act      : accepted ACT to this bank (only asserted when o_idle)
//   i_pre      : accepted PRE to this bank (ignored when idle/precharging)
//   i_row      : row address captured on ACT
//   o_idle     : bank may take an ACT this cycle
//   o_active   : bank may take RD/WR this cycle
//   o_open     : registered ACTIVATING or ACTIVE
//   o_row      : row opened by the last accepted ACT
// ---------------------------------------------------------------------------
module ddr3_bank_fsm
  import ddr3_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int TRCD     = DEF_TRCD,
  parameter int TRP      = DEF_TRP
) (
  input  logic                ck,
  input  logic                rst_n,
  input  logic                i_act,
  input  logic                i_pre,
  input  logic [ROW_BITS-1:0] i_row,
  output logic                o_idle,
  output logic                o_active,
  output logic                o_open,
  output logic [ROW_BITS-1:0] o_row
);

  localparam int T_MAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int T_W   = $clog2(T_MAX);
  localparam logic [T_W-1:0] TRCD_LOAD = T_W'(TRCD - 1);
  localparam logic [T_W-1:0] TRP_LOAD  = T_W'(TRP - 1);

  bank_state_e         r_state;
  bank_state_e         w_effState;
  logic [T_W-1:0]      r_timer;
  logic [ROW_BITS-1:0] r_row;

  // A timed state whose counter has reached zero is already finished from the
  // point of view of a command sampled this edge; this is what makes a
  // command exactly TRCD/TRP edges later legal and one edge earlier illegal.
  always_comb begin
    w_effState = r_state;
    if (r_timer == '0) begin
      if (r_state == BANK_ACTIVATING)
        w_effState = BANK_ACTIVE;
      else if (r_state == BANK_PRECHARGING)
        w_effState = BANK_IDLE;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BANK_IDLE;
      r_timer <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_effState;
      if (r_timer != '0)
        r_timer <= r_timer - T_W'(1);
      case (w_effState)
        BANK_IDLE: begin
          if (i_act) begin
            r_state <= BANK_ACTIVATING;
            r_timer <= TRCD_LOAD;
            r_row   <= i_row;
          end
        end
        BANK_ACTIVATING, BANK_ACTIVE: begin
          if (i_pre) begin
            r_state <= BANK_PRECHARGING;
            r_timer <= TRP_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_idle   = (w_effState == BANK_IDLE);
  assign o_active = (w_effState == BANK_ACTIVE);
  assign o_open   = (r_state == BANK_ACTIVATING) || (r_state == BANK_ACTIVE);
  assign o_row    = r_row;

endmodule

// File: rtl/ddr3_cmd_decoder.sv
// ---------------------------------------------------------------------------
// ddr3_cmd_decoder
// Memory-side DDR3 command decoder and protocol checker. Decodes the command
// pins every rising ck, keeps the three mode registers, tracks every bank and
// the global tRFC window, and reports each command plus any violation one
// cycle later.
//   ck, rst_n : clock, async active-low reset
//   bus       : ddr3_cmd_decoder_if slave modport (pins in, reports out)
// ---------------------------------------------------------------------------
module ddr3_cmd_decoder
  import ddr3_pkg::*;
#(
  parameter int BA_BITS   = DEF_BA_BITS,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int ROW_BITS  = DEF_ROW_BITS,
  parameter int TRCD      = DEF_TRCD,
  parameter int TRP       = DEF_TRP,
  parameter int TRFC      = DEF_TRFC
) (
  input  logic              ck,
  input  logic              rst_n,
  ddr3_cmd_decoder_if.slave bus
);

  localparam int NUM_BANKS = 1 << BA_BITS;
  localparam int RFC_W     = $clog2(TRFC);
  localparam logic [RFC_W-1:0] RFC_LOAD = RFC_W'(TRFC - 1);

  ddr3_cmd_e              w_cmd;
  logic                   w_isCmd;
  ddr3_err_e              w_err;
  logic                   w_accept;
  logic                   w_anyBusy;
  logic [NUM_BANKS-1:0]   w_bankSel;
  logic [NUM_BANKS-1:0]   w_actVec;
  logic [NUM_BANKS-1:0]   w_preVec;
  logic [NUM_BANKS-1:0]   w_bankIdle;
  logic [NUM_BANKS-1:0]   w_bankActive;
  logic [NUM_BANKS-1:0]   w_bankOpen;
  logic [ROW_BITS-1:0]    w_bankRow [NUM_BANKS];

  logic [RFC_W-1:0]       r_rfcTimer;
  logic [ADDR_BITS-1:0]   r_modeReg0;
  logic [ADDR_BITS-1:0]   r_modeReg1;
  logic [ADDR_BITS-1:0]   r_modeReg2;
  logic                   r_cmdValid;
  ddr3_cmd_e              r_cmdCode;
  logic [BA_BITS-1:0]     r_cmdBank;
  logic [ADDR_BITS-1:0]   r_cmdAddr;
  logic [ROW_BITS-1:0]    r_cmdRow;
  logic                   r_errValid;
  ddr3_err_e              r_errCode;

  assign w_cmd     = decodeCmd(bus.cke, bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n);
  assign w_isCmd   = (w_cmd != CMD_NOP) && (w_cmd != CMD_DES);
  assign w_bankSel = NUM_BANKS'(1) << bus.ba;
  assign w_anyBusy = ~&w_bankIdle;

  // Only the highest-priority violation is reported; a command inside the
  // refresh window is flagged for that alone, whatever else is wrong with it.
  always_comb begin
    w_err = ERR_NONE;
    if (w_isCmd) begin
      if (r_rfcTimer != '0)
        w_err = ERR_TRFC;
      else if ((w_cmd == CMD_ACT) && !w_bankIdle[bus.ba])
        w_err = ERR_ACT_OPEN;
      else if (((w_cmd == CMD_RD) || (w_cmd == CMD_WR)) && !w_bankActive[bus.ba])
        w_err = ERR_NOT_ACTIVE;
      else if ((w_cmd == CMD_REF) && w_anyBusy)
        w_err = ERR_REF_OPEN;
      else if (((w_cmd == CMD_MRS) || (w_cmd == CMD_ZQ)) && w_anyBusy)
        w_err = ERR_MRS_OPEN;
    end
  end

  // Errored commands never reach the banks, timers or mode registers.
  assign w_accept = w_isCmd && (w_err == ERR_NONE);
  assign w_actVec = (w_accept && (w_cmd == CMD_ACT)) ? w_bankSel : '0;
  assign w_preVec = (w_accept && (w_cmd == CMD_PRE)) ?
                    (bus.addr[10] ? '1 : w_bankSel) : '0;

  generate
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      ddr3_bank_fsm #(
        .ROW_BITS (ROW_BITS),
        .TRCD     (TRCD),
        .TRP      (TRP)
      ) u_bank (
        .ck       (ck),
        .rst_n    (rst_n),
        .i_act    (w_actVec[g]),
        .i_pre    (w_preVec[g]),
        .i_row    (bus.addr[ROW_BITS-1:0]),
        .o_idle   (w_bankIdle[g]),
        .o_active (w_bankActive[g]),
        .o_open   (w_bankOpen[g]),
        .o_row    (w_bankRow[g])
      );
    end
  endgenerate

  // Global refresh window: reloads on an accepted REF, then counts down
  // regardless of cke.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n)
      r_rfcTimer <= '0;
    else if (w_accept && (w_cmd == CMD_REF))
      r_rfcTimer <= RFC_LOAD;
    else if (r_rfcTimer != '0)
      r_rfcTimer <= r_rfcTimer - RFC_W'(1);
  end

  // Mode registers; an MRS to ba 3 or above is reported but stores nothing.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_modeReg0 <= '0;
      r_modeReg1 <= '0;
      r_modeReg2 <= '0;
    end else if (w_accept && (w_cmd == CMD_MRS)) begin
      case (bus.ba)
        BA_BITS'(0): r_modeReg0 <= bus.addr;
        BA_BITS'(1): r_modeReg1 <= bus.addr;
        BA_BITS'(2): r_modeReg2 <= bus.addr;
        default: ;
      endcase
    end
  end

  // Report registers: the valid/error pulses last one cycle, the command
  // fields hold the last real command until the next one arrives.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_cmdValid <= 1'b0;
      r_cmdCode  <= CMD_NOP;
      r_cmdBank  <= '0;
      r_cmdAddr  <= '0;
      r_cmdRow   <= '0;
      r_errValid <= 1'b0;
      r_errCode  <= ERR_NONE;
    end else begin
      r_cmdValid <= w_isCmd;
      r_errValid <= (w_err != ERR_NONE);
      r_errCode  <= w_err;
      if (w_isCmd) begin
        r_cmdCode <= w_cmd;
        r_cmdBank <= bus.ba;
        r_cmdAddr <= bus.addr;
        r_cmdRow  <= w_bankRow[bus.ba];
      end
    end
  end

  assign bus.cmd_valid = r_cmdValid;
  assign bus.cmd_code  = r_cmdCode;
  assign bus.cmd_bank  = r_cmdBank;
  assign bus.cmd_addr  = r_cmdAddr;
  assign bus.cmd_row   = r_cmdRow;
  assign bus.mode_reg0 = r_modeReg0;
  assign bus.mode_reg1 = r_modeReg1;
  assign bus.mode_reg2 = r_modeReg2;
  assign bus.bank_open = w_bankOpen;
  assign bus.err_valid = r_errValid;
  assign bus.err_code  = r_errCode;

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_ddr3_cmd_decoder
// Directed bench for ddr3_cmd_decoder: each driven command pushes its
// expected report onto a scoreboard, which is popped one edge later.
// ---------------------------------------------------------------------------
module tb_ddr3_cmd_decoder;

  localparam logic [3:0] P_MRS = 4'b0000;
  localparam logic [3:0] P_REF = 4'b0001;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_ZQ  = 4'b0110;
  localparam logic [3:0] P_NOP = 4'b0111;
  localparam logic [3:0] P_DES_ACT = 4'b1011;

  localparam logic [2:0] E_OK      = 3'd0;
  localparam logic [2:0] E_TRFC    = 3'd1;
  localparam logic [2:0] E_ACTOPEN = 3'd2;
  localparam logic [2:0] E_NOTACT  = 3'd3;
  localparam logic [2:0] E_REFOPEN = 3'd4;
  localparam logic [2:0] E_MRSOPEN = 3'd5;

  typedef struct {
    logic        valid;
    logic [3:0]  code;
    logic [2:0]  bank;
    logic [13:0] addr;
    logic        chkRow;
    logic [13:0] row;
    logic [2:0]  err;
  } exp_t;

  logic ck = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  always #5 ck = ~ck;

  ddr3_cmd_decoder_if #(.BA_BITS(3), .ADDR_BITS(14), .ROW_BITS(14)) bus ();

  ddr3_cmd_decoder #(
    .BA_BITS(3), .ADDR_BITS(14), .ROW_BITS(14),
    .TRCD(6), .TRP(6), .TRFC(44)
  ) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mkExp(input logic v, input logic [3:0] code,
                                 input logic [2:0] b, input logic [13:0] a,
                                 input logic chk, input logic [13:0] row,
                                 input logic [2:0] err);
    exp_t e;
    e.valid = v; e.code = code; e.bank = b; e.addr = a;
    e.chkRow = chk; e.row = row; e.err = err;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    check("scoreboardDepth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("cmdValid", 32'(bus.cmd_valid), 32'(e.valid));
      if (e.valid) begin
        check("cmdCode", 32'(bus.cmd_code), 32'(e.code));
        check("cmdBank", 32'(bus.cmd_bank), 32'(e.bank));
        check("cmdAddr", 32'(bus.cmd_addr), 32'(e.addr));
        if (e.chkRow)
          check("cmdRow", 32'(bus.cmd_row), 32'(e.row));
      end
      check("errValid", 32'(bus.err_valid), 32'(e.err != 3'd0));
      check("errCode", 32'(bus.err_code), 32'(e.err));
    end
  endtask

  task automatic applyStimulus(input logic cke, input logic [3:0] pins,
                               input logic [2:0] ba, input logic [13:0] addr,
                               input exp_t e);
    @(negedge ck);
    bus.cke = cke;
    {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = pins;
    bus.ba = ba;
    bus.addr = addr;
    sb.push_back(e);
    @(posedge ck);
    #1;
    checkOutput();
  endtask

  task automatic issue(input logic [3:0] pins, input logic [2:0] ba,
                       input logic [13:0] addr, input logic [2:0] err);
    applyStimulus(1'b1, pins, ba, addr, mkExp(1'b1, pins, ba, addr, 1'b0, 14'h0, err));
  endtask

  task automatic issueRow(input logic [3:0] pins, input logic [2:0] ba,
                          input logic [13:0] addr, input logic [13:0] row);
    applyStimulus(1'b1, pins, ba, addr, mkExp(1'b1, pins, ba, addr, 1'b1, row, E_OK));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, P_NOP, 3'd0, 14'h0, mkExp(1'b0, 4'h0, 3'd0, 14'h0, 1'b0, 14'h0, E_OK));
  endtask

  task automatic checkResetValues();
    check("rstCmdValid", 32'(bus.cmd_valid), 32'd0);
    check("rstCmdCode", 32'(bus.cmd_code), 32'(P_NOP));
    check("rstCmdBank", 32'(bus.cmd_bank), 32'd0);
    check("rstCmdAddr", 32'(bus.cmd_addr), 32'd0);
    check("rstCmdRow", 32'(bus.cmd_row), 32'd0);
    check("rstModeReg0", 32'(bus.mode_reg0), 32'd0);
    check("rstModeReg1", 32'(bus.mode_reg1), 32'd0);
    check("rstModeReg2", 32'(bus.mode_reg2), 32'd0);
    check("rstBankOpen", 32'(bus.bank_open), 32'd0);
    check("rstErrValid", 32'(bus.err_valid), 32'd0);
    check("rstErrCode", 32'(bus.err_code), 32'd0);
  endtask

  initial begin
    bus.cke = 1'b1;
    {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = P_NOP;
    bus.ba = 3'd0;
    bus.addr = 14'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge ck);
    @(negedge ck);
    checkResetValues();
    rst_n = 1'b1;

    $display("[TB] mode registers");
    issue(P_MRS, 3'd1, 14'h0044, E_OK);
    check("modeReg1", 32'(bus.mode_reg1), 32'h0044);
    issue(P_MRS, 3'd0, 14'h1520, E_OK);
    issue(P_MRS, 3'd2, 14'h0018, E_OK);
    issue(P_MRS, 3'd3, 14'h0123, E_OK);
    check("modeReg0", 32'(bus.mode_reg0), 32'h1520);
    check("modeReg1Kept", 32'(bus.mode_reg1), 32'h0044);
    check("modeReg2", 32'(bus.mode_reg2), 32'h0018);

    $display("[TB] tRCD / tRP on bank 2");
    issue(P_ACT, 3'd2, 14'h1ABC, E_OK);
    check("bankOpenAct2", 32'(bus.bank_open), 32'h04);
    idle(5);
    issueRow(P_RD, 3'd2, 14'h0010, 14'h1ABC);
    issue(P_PRE, 3'd2, 14'h0000, E_OK);
    check("bankOpenPre2", 32'(bus.bank_open), 32'h00);
    idle(5);
    issue(P_ACT, 3'd2, 14'h0222, E_OK);
    idle(4);
    issue(P_RD, 3'd2, 14'h0020, E_NOTACT);
    issueRow(P_RD, 3'd2, 14'h0020, 14'h0222);
    issue(P_WR, 3'd4, 14'h0030, E_NOTACT);

    $display("[TB] precharge all");
    issue(P_ACT, 3'd0, 14'h0011, E_OK);
    issue(P_ACT, 3'd5, 14'h0055, E_OK);
    check("bankOpen025", 32'(bus.bank_open), 32'h25);
    issue(P_PRE, 3'd0, 14'h0400, E_OK);
    check("bankOpenPreAll", 32'(bus.bank_open), 32'h00);
    idle(4);
    issue(P_ACT, 3'd0, 14'h0011, E_ACTOPEN);
    issue(P_ACT, 3'd0, 14'h0012, E_OK);
    check("bankOpenAct0", 32'(bus.bank_open), 32'h01);
    issue(P_ACT, 3'd0, 14'h0013, E_ACTOPEN);

    $display("[TB] refresh");
    issue(P_REF, 3'd0, 14'h0000, E_REFOPEN);
    idle(3);
    issueRow(P_RD, 3'd0, 14'h0040, 14'h0012);
    issue(P_PRE, 3'd0, 14'h0000, E_OK);
    idle(4);
    issue(P_REF, 3'd0, 14'h0000, E_REFOPEN);
    issue(P_REF, 3'd0, 14'h0000, E_OK);
    idle(42);
    issue(P_ACT, 3'd1, 14'h0101, E_TRFC);
    issue(P_ACT, 3'd1, 14'h0101, E_OK);
    check("bankOpenAct1", 32'(bus.bank_open), 32'h02);

    $display("[TB] cke low, deselect, ZQ/MRS with open bank");
    applyStimulus(1'b0, P_ACT, 3'd3, 14'h0333, mkExp(1'b0, 4'h0, 3'd0, 14'h0, 1'b0, 14'h0, E_OK));
    check("bankOpenCkeLow", 32'(bus.bank_open), 32'h02);
    applyStimulus(1'b1, P_DES_ACT, 3'd3, 14'h0333, mkExp(1'b0, 4'h0, 3'd0, 14'h0, 1'b0, 14'h0, E_OK));
    check("bankOpenDes", 32'(bus.bank_open), 32'h02);
    issue(P_ZQ, 3'd0, 14'h0400, E_MRSOPEN);
    issue(P_MRS, 3'd2, 14'h0008, E_MRSOPEN);
    check("modeReg2Kept", 32'(bus.mode_reg2), 32'h0018);

    $display("[TB] reset mid-tRCD");
    issue(P_ACT, 3'd6, 14'h0666, E_OK);
    idle(2);
    @(negedge ck);
    rst_n = 1'b0;
    #1;
    checkResetValues();
    @(posedge ck);
    @(negedge ck);
    rst_n = 1'b1;
    issue(P_RD, 3'd6, 14'h0060, E_NOTACT);
    check("bankOpenAfterRst", 32'(bus.bank_open), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
